// File: rtl/multiplication_seq_if.sv
// Start/operand handshake and hi/lo result bundle for the sequential multiplier.
// The requester drives through master; the multiplier implements slave.
interface multiplication_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, a, b,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/multiplication_seq.sv
// Iterative shift-and-add unsigned multiplier, one partial product per clock.
// Optional build macro MULT_EARLY_TERM_EN finishes as soon as the multiplier runs out of set bits.
module multiplication_seq #(
    parameter int WIDTH = 32
) (
    input logic                clock,
    input logic                reset_n,
    multiplication_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   w_mplier_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_last;

    // The sum cannot carry out: the full product of two WIDTH-bit values fits in 2*WIDTH bits.
    always_comb begin
        w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        w_mplier_next = r_mplier >> 1;
        w_cnt_next    = r_cnt - CNT_ONE;
`ifdef MULT_EARLY_TERM_EN
        w_last        = (w_cnt_next == '0) || (w_mplier_next == '0);
`else
        w_last        = (w_cnt_next == '0);
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_acc    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, bus.a};
                        r_mplier <= bus.b;
                        r_cnt    <= CNT_INIT;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_next;
                    r_cnt    <= w_cnt_next;
                    // hi/lo only move here, so they keep the previous product while busy.
                    if (w_last) begin
                        {r_hi, r_lo} <= w_acc_next;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule
